display_scanner: RTL and testbench

- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Holds a shadow copy of a packed BCD value and steps through the digits at a fixed scan rate. Each slot drives one BCD nibble plus a blank flag into the downstream per-digit segment decoder, and an active-low anode select to the display.
- Adds leading-zero suppression, per-digit blink, invalid-code blanking and an anode guard interval for anti-ghosting.

---
 rtl/display_scanner_pkg.sv | 11 +
 rtl/display_scanner_scan_timer.sv | 69 ++++++
 rtl/display_scanner.sv | 88 ++++++++
 tb/tb_display_scanner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package display_scanner_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Returns a word with the low n bits set, i.e. every anode switched off.
  function automatic logic [7:0] anode_off(input int unsigned n);
    return 8'((1 << n) - 1);
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Slot timing for the scanner: slot counter, digit index, frame counter and blink phase.
module scan_timer #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  output logic [$clog2(DIGITS)-1:0] idx,
  output logic                      in_guard,
  output logic                      phase
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (run) begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          idx_d = '0;
          // Blink phase flips once per BLINK_FRAMES complete scans.
          if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            phase_d = ~phase_q;
          end else begin
            frame_d = frame_q + FRM_W'(1);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign idx      = idx_q;
  assign in_guard = (cnt_q < CNT_W'(GUARD));
  assign phase    = phase_q;

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed driver for a common-anode 7-segment display with blanking and blink.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  lzb_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [3:0]            bcdout,
  output logic                  blank,
  output logic [DIGITS-1:0]     an
);

  localparam int                IDX_W  = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] AN_OFF = DIGITS'(anode_off(DIGITS));

  logic [1:0]            sync_q, sync_d;
  logic                  run;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  blank_q, blank_d;
  logic [IDX_W-1:0]      idx;
  logic                  in_guard;
  logic                  phase;
  logic [4*DIGITS-1:0]   upper;

  scan_timer #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .idx      (idx),
    .in_guard (in_guard),
    .phase    (phase)
  );

  // Everything stays frozen until reset release has passed through both sync flops.
  always_comb begin
    sync_d   = {sync_q[0], 1'b1};
    run      = sync_q[1];
    shadow_d = (run && load) ? value : shadow_q;
    upper    = shadow_q >> (4 * idx);
    an_d     = an_q;
    bcd_d    = bcd_q;
    blank_d  = blank_q;
    if (run) begin
      an_d    = in_guard ? AN_OFF : ~(DIGITS'(1) << idx);
      bcd_d   = upper[3:0];
      // Digit 0 is never zero-suppressed; higher digits blank when they and all above are 0.
      blank_d = (upper[3:0] > BCD_MAX)
              || (lzb_en && (idx != '0) && (upper == '0))
              || (blink_mask[idx] && phase);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      shadow_q <= '0;
      an_q     <= AN_OFF;
      bcd_q    <= '0;
      blank_q  <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      bcd_q    <= bcd_d;
      blank_q  <= blank_d;
    end
  end

  assign an     = an_q;
  assign bcdout = bcd_q;
  assign blank  = blank_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized self-checking bench for display_scanner against a slot-arithmetic reference model.
module tb_display_scanner;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  bcdout;
  logic        blank;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  display_scanner #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .lzb_en     (lzb_en),
    .blink_mask (blink_mask),
    .bcdout     (bcdout),
    .blank      (blank),
    .an         (an)
  );

  always #5 clk = ~clk;

  // Reference model: n counts running cycles; slot, digit and blink phase follow by division.
  int          rel;
  int          n;
  logic [15:0] m_shadow;
  logic [3:0]  e_an;
  logic [3:0]  e_bcd;
  logic        e_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel      = 0;
      n        = 0;
      m_shadow = '0;
      e_an     = 4'hF;
      e_bcd    = 4'h0;
      e_blank  = 1'b1;
    end else if (rel < 2) begin
      rel++;
    end else begin
      int slot, pos, d, ph;
      slot    = n / SCAN_DIV;
      pos     = n % SCAN_DIV;
      d       = slot % DIGITS;
      ph      = (slot / DIGITS / BLINK_FRAMES) % 2;
      e_an    = (pos < GUARD) ? 4'hF : ~(4'b0001 << d);
      e_bcd   = 4'((m_shadow >> (4 * d)) & 16'hF);
      e_blank = (e_bcd > 4'd9)
             || (lzb_en && d != 0 && (m_shadow >> (4 * d)) == 16'h0)
             || (blink_mask[d] && ph == 1);
      if (load) m_shadow = value;
      n++;
    end
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    value = 16'h1234;
    load  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (an !== 4'hF || blank !== 1'b1 || bcdout !== 4'h0) begin
        bad++;
        $display("[TB] FAIL reset_hold an=%b blank=%b bcd=%h required an=1111 blank=1 bcd=0", an, blank, bcdout);
      end
    end
    load  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (an !== 4'hF || blank !== 1'b1 || bcdout !== 4'h0) begin
        bad++;
        $display("[TB] FAIL reset_sync%0d an=%b blank=%b bcd=%h required an=1111 blank=1 bcd=0", i, an, blank, bcdout);
      end
    end
    @(negedge clk);
    total++;
    if (an !== 4'hF || blank !== 1'b0 || bcdout !== 4'h0) begin
      bad++;
      $display("[TB] FAIL reset_first_scan an=%b blank=%b bcd=%h required an=1111 blank=0 bcd=0", an, blank, bcdout);
    end
  endtask

  task automatic test_basic_scan();
    lzb_en     = 1'b0;
    blink_mask = '0;
    do_load(16'h1234);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL basic_scan an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
  endtask

  task automatic test_leading_zeros();
    lzb_en = 1'b1;
    do_load(16'h0050);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL lzb_0050 an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
    do_load(16'h0000);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL lzb_0000 an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_invalid_blink();
    blink_mask = '0;
    do_load(16'h12A4);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL invalid_code an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
    blink_mask = 4'b0001;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL blink an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_load_on_wrap();
    int budget;
    do_load(16'h1234);
    budget = 0;
    while ((n % SCAN_DIV) != SCAN_DIV - 1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if ((n % SCAN_DIV) != SCAN_DIV - 1) begin
      bad++;
      $display("[TB] FAIL wrap_wait timed out after %0d cycles", budget);
    end
    value = 16'h9999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    @(negedge clk);
    total++;
    if (bcdout !== 4'h9 || blank !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrap_latency bcd=%h blank=%b required bcd=9 blank=0", bcdout, blank);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== 4'h9 || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL wrap_no_stale an=%b bcd=%h blank=%b required an=%b bcd=9 blank=%b", an, bcdout, blank, e_an, e_blank);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL random an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lzb_en = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(16'h5678);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (an !== 4'hF || blank !== 1'b1 || bcdout !== 4'h0) begin
      bad++;
      $display("[TB] FAIL async_reset an=%b blank=%b bcd=%h required an=1111 blank=1 bcd=0", an, blank, bcdout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (an !== e_an || bcdout !== e_bcd || blank !== e_blank) begin
        bad++;
        $display("[TB] FAIL after_async an=%b bcd=%h blank=%b required an=%b bcd=%h blank=%b", an, bcdout, blank, e_an, e_bcd, e_blank);
      end
    end
  endtask

  initial begin
    $display("[TB] starting display_scanner bench");
    test_reset();
    test_basic_scan();
    test_leading_zeros();
    test_invalid_blink();
    test_load_on_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
